// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//
// The control path issues a one-cycle start and stalls while busy is high. It
// captures Result on the done pulse. Operands are reduced to magnitudes, then
// UNROLL quotient bits are resolved per CALC cycle. One FIXUP cycle applies the
// signs and writes Result. Division by zero and signed overflow are resolved
// straight from IDLE.
//
// Optional feature macro: DIV_EARLY_OUT_EN
//   When defined, IDLE also short-cuts |A| < |B| (quotient 0, remainder A).
//   When undefined, those operands take the full iterative path.
//
// Parameters:
//   XLEN    operand/result width
//   UNROLL  quotient bits per CALC cycle (1, 2 or 4; must divide XLEN)
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   start   in   request pulse, honoured only in IDLE
//   op      in   0=DIV 1=DIVU 2=REM 3=REMU
//   A, B    in   dividend / divisor, sampled with start
//   busy    out  high from the cycle after acceptance through the done cycle
//   done    out  single-cycle completion pulse
//   Result  out  quotient or remainder, held until the next accepted start
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] Result
);

    localparam int N  = XLEN / UNROLL;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Two's-complement negation.
    function automatic logic [XLEN-1:0] neg2(input logic [XLEN-1:0] x);
        neg2 = ~x + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of an operand; unsigned operands pass through unchanged.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
        if (sgn && x[XLEN-1]) begin
            mag = neg2(x);
        end else begin
            mag = x;
        end
    endfunction

    state_e            state_q, state_d;
    logic [XLEN-1:0]   dvd_q, dvd_d;      // |A| shifting out, quotient bits shifting in
    logic [XLEN-1:0]   rem_q, rem_d;      // partial remainder
    logic [XLEN-1:0]   dsr_q, dsr_d;      // |B|
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              is_rem_q, is_rem_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              is_signed_s;
    logic [XLEN-1:0]   a_mag_s;
    logic [XLEN-1:0]   b_mag_s;
    logic              b_zero_s;
    logic              ovf_s;
    logic [XLEN-1:0]   rem_t_s;
    logic [XLEN-1:0]   dvd_t_s;
    logic [XLEN:0]     trial_s;
`ifdef DIV_EARLY_OUT_EN
    logic              early_s;
`endif

    assign busy   = busy_q;
    assign done   = done_q;
    assign Result = result_q;

    // Operand decode for the request presented in IDLE.
    always_comb begin
        is_signed_s = ~op[0];
        a_mag_s     = mag(A, is_signed_s);
        b_mag_s     = mag(B, is_signed_s);
        b_zero_s    = (B == {XLEN{1'b0}});
        ovf_s       = is_signed_s && (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == {XLEN{1'b1}});
`ifdef DIV_EARLY_OUT_EN
        early_s     = (a_mag_s < b_mag_s);
`endif
    end

    // UNROLL restoring steps: shift one dividend bit in, trial-subtract, keep on no borrow.
    always_comb begin
        rem_t_s = rem_q;
        dvd_t_s = dvd_q;
        trial_s = {(XLEN+1){1'b0}};
        for (int k = 0; k < UNROLL; k++) begin
            trial_s = {rem_t_s, dvd_t_s[XLEN-1]} - {1'b0, dsr_q};
            if (!trial_s[XLEN]) begin
                rem_t_s = trial_s[XLEN-1:0];
                dvd_t_s = {dvd_t_s[XLEN-2:0], 1'b1};
            end else begin
                // No borrow-free subtract: the shifted remainder is below |B| and fits XLEN bits.
                rem_t_s = {rem_t_s[XLEN-2:0], dvd_t_s[XLEN-1]};
                dvd_t_s = {dvd_t_s[XLEN-2:0], 1'b0};
            end
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        rem_d     = rem_q;
        dsr_d     = dsr_q;
        cnt_d     = cnt_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_rem_d  = op[1];
                    neg_quo_d = is_signed_s & (A[XLEN-1] ^ B[XLEN-1]);
                    neg_rem_d = is_signed_s & A[XLEN-1];
                    dvd_d     = a_mag_s;
                    dsr_d     = b_mag_s;
                    rem_d     = {XLEN{1'b0}};
                    cnt_d     = {CW{1'b0}};
                    if (b_zero_s) begin
                        result_d = op[1] ? A : {XLEN{1'b1}};
                        state_d  = S_DONE;
                    end else if (ovf_s) begin
                        result_d = op[1] ? {XLEN{1'b0}} : A;
                        state_d  = S_DONE;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (early_s) begin
                        // A signed A already carries the sign the remainder needs.
                        result_d = op[1] ? A : {XLEN{1'b0}};
                        state_d  = S_DONE;
                    end
`endif
                    else begin
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                rem_d = rem_t_s;
                dvd_d = dvd_t_s;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_FIXUP;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_FIXUP: begin
                if (is_rem_q) begin
                    result_d = neg_rem_q ? neg2(rem_q) : rem_q;
                end else begin
                    result_d = neg_quo_q ? neg2(dvd_q) : dvd_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            dvd_q     <= {XLEN{1'b0}};
            rem_q     <= {XLEN{1'b0}};
            dsr_q     <= {XLEN{1'b0}};
            cnt_q     <= {CW{1'b0}};
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= {XLEN{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            rem_q     <= rem_d;
            dsr_q     <= dsr_d;
            cnt_q     <= cnt_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit -- directed self-checking bench for div_unit.
// Two instances share clock, reset and operands: dut0 (UNROLL=1) and
// dut4 (UNROLL=4), each with its own start line. Expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_div_unit;

`ifdef DIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 34;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start4;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy0, done0, busy4, done4;
    logic [31:0] res0, res4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_unit #(.XLEN(32), .UNROLL(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .op(op), .A(a), .B(b),
        .busy(busy0), .done(done0), .Result(res0)
    );

    div_unit #(.XLEN(32), .UNROLL(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .op(op), .A(a), .B(b),
        .busy(busy4), .done(done4), .Result(res4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge, then scramble the operands.
    task automatic kick(input bit sel, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        step();
        op = o;
        a  = x;
        b  = y;
        if (sel) start4 = 1'b1;
        else     start0 = 1'b1;
        step();
        start0 = 1'b0;
        start4 = 1'b0;
        op     = 2'd0;
        a      = 32'hDEADBEEF;
        b      = 32'h00000000;
    endtask

    // Now one cycle after acceptance; advance until done (bounded).
    task automatic wait_done(input bit sel, input int first, output int lat);
        lat = first;
        while (((sel ? done4 : done0) !== 1'b1) && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic run(input string tag, input bit sel, input logic [1:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input int exp_lat);
        int lat;
        kick(sel, o, x, y);
        wait_done(sel, 1, lat);
        check({tag, " result"}, sel ? res4 : res0, exp);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " busy@done"}, {31'd0, sel ? busy4 : busy0}, 32'd1);
        step();
        check({tag, " done pulse"}, {31'd0, sel ? done4 : done0}, 32'd0);
        check({tag, " held"}, sel ? res4 : res0, exp);
    endtask

    initial begin
        int lat;
        int pulses;
        rst    = 1'b1;
        start0 = 1'b0;
        start4 = 1'b0;
        op     = 2'd0;
        a      = 32'd0;
        b      = 32'd0;
        step();
        step();
        rst = 1'b0;
        check("reset busy0",   {31'd0, busy0}, 32'd0);
        check("reset done0",   {31'd0, done0}, 32'd0);
        check("reset result0", res0, 32'd0);
        check("reset busy4",   {31'd0, busy4}, 32'd0);
        check("reset result4", res4, 32'd0);

        // Normal path, UNROLL=1
        run("divu 100/7",  1'b0, 2'd1, 32'd100, 32'd7, 32'd14, 34);
        run("remu 100/7",  1'b0, 2'd3, 32'd100, 32'd7, 32'd2,  34);
        run("div -7/2",    1'b0, 2'd0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
        run("rem -7/2",    1'b0, 2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
        run("div 7/-2",    1'b0, 2'd0, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34);
        run("rem 7/-2",    1'b0, 2'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 34);
        run("rem -7/-2",   1'b0, 2'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 34);

        // Special cases resolved in IDLE
        run("div x/0",     1'b0, 2'd0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 1);
        run("divu x/0",    1'b0, 2'd1, 32'h12345678, 32'd0, 32'hFFFFFFFF, 1);
        run("rem x/0",     1'b0, 2'd2, 32'h12345678, 32'd0, 32'h12345678, 1);
        run("remu x/0",    1'b0, 2'd3, 32'h12345678, 32'd0, 32'h12345678, 1);
        run("div ovf",     1'b0, 2'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run("rem ovf",     1'b0, 2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

        // Second start in flight must be ignored
        kick(1'b0, 2'd1, 32'd1000, 32'd10);
        step(); step(); step(); step();
        op     = 2'd1;
        a      = 32'd5;
        b      = 32'd1;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        check("ignored start busy", {31'd0, busy0}, 32'd1);
        wait_done(1'b0, 6, lat);
        check("ignored start result",  res0, 32'd100);
        check("ignored start latency", 32'(lat), 32'd34);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done0 === 1'b1) pulses++;
        end
        check("ignored start extra done", 32'(pulses), 32'd0);

        // Reset mid-CALC aborts
        kick(1'b0, 2'd1, 32'd50000, 32'd7);
        for (int i = 0; i < 9; i++) step();
        check("pre-abort busy", {31'd0, busy0}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort busy",   {31'd0, busy0}, 32'd0);
        check("abort done",   {31'd0, done0}, 32'd0);
        check("abort result", res0, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done0 === 1'b1) pulses++;
        end
        check("abort no done", 32'(pulses), 32'd0);
        run("divu 9/3 after abort", 1'b0, 2'd1, 32'd9, 32'd3, 32'd3, 34);

        // UNROLL=4 instance: N=8, latency 10
        run("u4 divu ffffffff/16", 1'b1, 2'd1, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 10);
        run("u4 div -100/7",       1'b1, 2'd0, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 10);
        run("u4 rem -100/7",       1'b1, 2'd2, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 10);

        // Small dividend: early-out latency depends on the build
        run("divu 3/5",  1'b0, 2'd1, 32'd3, 32'd5, 32'd0, EO_LAT);
        run("rem -3/5",  1'b0, 2'd2, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFD, EO_LAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
